// File: rtl/mod7_sequence_checker_pkg.sv
// Shared defaults and state encoding for the mod-7 sequence checker.
package mod7_chk_pkg;

  localparam int DEF_MODULUS   = 7;
  localparam int DEF_CW        = 3;
  localparam int DEF_ERR_CNT_W = 8;

  localparam logic [DEF_ERR_CNT_W-1:0] ERR_SAT = '1;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/mod7_sequence_checker_incr.sv
// Combinational modular increment: (val + 1) mod MODULUS via compare-and-wrap.
module mod7_incr #(
  parameter int MODULUS = 7,
  parameter int CW      = 3
) (
  input  logic [CW-1:0] val_i,
  output logic [CW-1:0] val_o
);

  always_comb begin
    if (val_i == CW'(MODULUS - 1)) val_o = '0;
    else                           val_o = val_i + CW'(1);
  end

endmodule

// File: rtl/mod7_sequence_checker.sv
// Mod-7 count-stream checker: locks after LOCK_COUNT legal steps, then flags deviations.
// Optional MOD7_CHK_STICKY_EN adds err_sticky, set on the first error until reset.
module mod7_sequence_checker
  import mod7_chk_pkg::*;
#(
  parameter int MODULUS    = DEF_MODULUS,
  parameter int CW         = DEF_CW,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CW-1:0]        count_in,
  input  logic                 count_valid,
  output logic                 locked,
  output logic [CW-1:0]        expected,
  output logic                 err_pulse,
  output logic                 wrap_pulse,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef MOD7_CHK_STICKY_EN
  ,
  output logic                 err_sticky
`endif
);

  localparam int RW = $clog2(LOCK_COUNT + 1);

  state_e               state_q, state_d;
  logic [RW-1:0]        run_q, run_d;
  logic [CW-1:0]        last_q, last_d;
  logic                 have_last_q, have_last_d;
  logic [CW-1:0]        expected_q, expected_d;
  logic                 err_pulse_q, err_pulse_d;
  logic                 wrap_pulse_q, wrap_pulse_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [CW-1:0]        incr_val;
  logic                 legal;

  mod7_incr #(.MODULUS(MODULUS), .CW(CW)) u_incr (
    .val_i (count_in),
    .val_o (incr_val)
  );

  assign legal = {1'b0, count_in} < (CW + 1)'(MODULUS);

  // expected_q always holds incr(last_q) once have_last is set, so it doubles
  // as the SEARCH continuity reference.
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    last_d       = last_q;
    have_last_d  = have_last_q;
    expected_d   = expected_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;
    err_count_d  = err_count_q;
    if (count_valid) begin
      unique case (state_q)
        SEARCH: begin
          if (legal && have_last_q && (count_in == expected_q)) run_d = run_q + RW'(1);
          else if (legal)                                      run_d = RW'(1);
          else                                                 run_d = '0;
          if (run_d == RW'(LOCK_COUNT)) state_d = LOCKED;
        end
        LOCKED: begin
          if (count_in == expected_q) begin
            wrap_pulse_d = (count_in == '0);
          end else begin
            err_pulse_d = 1'b1;
            if (~&err_count_q) err_count_d = err_count_q + ERR_CNT_W'(1);
            state_d = SEARCH;
            run_d   = legal ? RW'(1) : '0;
          end
        end
        default: state_d = SEARCH;
      endcase
      if (legal) begin
        last_d      = count_in;
        have_last_d = 1'b1;
        expected_d  = incr_val;
      end else begin
        have_last_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= SEARCH;
      run_q        <= '0;
      last_q       <= '0;
      have_last_q  <= 1'b0;
      expected_q   <= '0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      last_q       <= last_d;
      have_last_q  <= have_last_d;
      expected_q   <= expected_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_count_q  <= err_count_d;
    end
  end

`ifdef MOD7_CHK_STICKY_EN
  logic err_sticky_q;

  always_ff @(posedge clk) begin
    if (!reset) err_sticky_q <= 1'b0;
    else        err_sticky_q <= err_sticky_q | err_pulse_d;
  end

  assign err_sticky = err_sticky_q;
`endif

  assign locked     = (state_q == LOCKED);
  assign expected   = expected_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err_count  = err_count_q;

endmodule
